// File: rtl/ssd_display_scheduler.sv
// ssd_display_scheduler: round-robin sharing of the two-digit display with a minimum dwell per value
module ssd_display_scheduler #(
   parameter int DWELL_CYCLES = 125_000_000,
   parameter int CNT_W        = 27
) (
   input  logic       i_clock_125MHz,
   input  logic       i_reset,
   input  logic       i_req0_valid,
   input  logic [7:0] i_req0_data,
   output logic       o_req0_ready,
   input  logic       i_req1_valid,
   input  logic [7:0] i_req1_data,
   output logic       o_req1_ready,
   input  logic       i_freeze,
   output logic [7:0] o_data,
   output logic       o_owner,
   output logic       o_busy
);
   typedef enum logic {IDLE, SHOW} state_t;
   localparam logic [CNT_W-1:0] LOAD = CNT_W'(DWELL_CYCLES - 1);
   state_t           state;
   logic [CNT_W-1:0] count;
   logic             last_grant;
   logic             open;
   // grant the lone valid requester, or on a tie the one not granted last time
   always_comb begin
      open         = state == IDLE && !i_freeze && !i_reset;
      o_req0_ready = open && i_req0_valid && (!i_req1_valid || last_grant);
      o_req1_ready = open && i_req1_valid && !(i_req0_valid && last_grant);
   end
   // accept one value, then hold it for the dwell window; freeze pauses everything
   always_ff @(posedge i_clock_125MHz or posedge i_reset) begin
      if (i_reset) begin
         state      <= IDLE;
         count      <= '0;
         last_grant <= 1'b1;
         o_data     <= 8'h00;
         o_owner    <= 1'b0;
         o_busy     <= 1'b0;
      end else if (state == IDLE) begin
         if (o_req0_ready || o_req1_ready) begin
            o_data     <= o_req1_ready ? i_req1_data : i_req0_data;
            o_owner    <= o_req1_ready;
            last_grant <= o_req1_ready;
            count      <= LOAD;
            state      <= SHOW;
            o_busy     <= 1'b1;
         end
      end else if (!i_freeze) begin
         if (count == '0) begin
            state  <= IDLE;
            o_busy <= 1'b0;
         end else begin
            count <= count - CNT_W'(1);
         end
      end
   end
endmodule

// File: doc/ssd_display_scheduler.md
Name: ssd_display_scheduler

Overview:
- Shares the single two-digit PmodSSD display between two producers, e.g. the ALS sample path and a debug/status source.
- Each producer offers an 8-bit value with a valid/ready handshake.
- The scheduler grants round-robin and holds each accepted value on the display for a guaranteed minimum dwell time.
- o_data drives the pmod_ssd i_data input directly.

Parameters:
- DWELL_CYCLES, 125_000_000, minimum number of clock cycles an accepted value stays displayed before another can be accepted (legal range 1 to 2^CNT_W).
- CNT_W, 27, width of the dwell counter.

Ports:
- i_clock_125MHz  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_req0_valid  in  1  requester 0 offers i_req0_data
- i_req0_data  in  8  requester 0 value, two hex nibbles
- o_req0_ready  out  1  scheduler accepts requester 0 this cycle
- i_req1_valid  in  1  requester 1 offers i_req1_data
- i_req1_data  in  8  requester 1 value
- o_req1_ready  out  1  scheduler accepts requester 1 this cycle
- i_freeze  in  1  hold the current display; no accepts, dwell counter paused
- o_data  out  8  value to the display driver
- o_owner  out  1  index of the requester whose value is shown
- o_busy  out  1  high while the dwell window is running

Behaviour:
- Reset, asynchronous: state=IDLE, o_data=8'h00, o_owner=0, o_busy=0, counter=0, last_grant=1 so requester 0 wins the first tie. o_req0_ready and o_req1_ready are 0 while i_reset is high.
- States: IDLE and SHOW. o_busy = (state==SHOW), registered.
- Readies are combinational from registered state and the current valids:
  - Both are 0 unless state==IDLE and i_freeze==0.
  - If only reqN is valid, only o_reqN_ready=1.
  - If both are valid, the requester that is not last_grant gets ready.
  - At most one ready is high per cycle.
  - A ready is never asserted without its matching valid.
- Transfer happens when valid && ready, in cycle T. At the T clock edge:
  - o_data <= that requester's data
  - o_owner <= N
  - last_grant <= N
  - counter <= DWELL_CYCLES-1
  - state <= SHOW
  - New o_data is visible from cycle T+1 (latency 1).
- In SHOW:
  - With i_freeze=0, counter decrements each cycle.
  - When counter==0 and i_freeze=0, state <= IDLE.
  - SHOW therefore lasts exactly DWELL_CYCLES unfrozen cycles (T+1..T+DWELL_CYCLES). The earliest next transfer is cycle T+DWELL_CYCLES+1.
  - Valids arriving during SHOW are not accepted; requesters must hold valid and data stable until ready.
- i_freeze:
  - In SHOW: counter and state hold.
  - In IDLE: no readies. o_data is unchanged.
  - Deassertion resumes exactly where it stopped.
- In IDLE, o_data and o_owner keep the last accepted value. The display never blanks.
- Reset mid-SHOW: everything returns to the reset values immediately. Any handshake in flight is lost.
- Requesters only see a ready when their valid is high, so sampling data without valid has no effect.

Test Plan (DWELL_CYCLES=4):
- Reset, then req0 valid with 8'h3A: o_req0_ready=1 the same cycle. Next cycle o_data=8'h3A, o_owner=0, o_busy=1. o_busy stays 1 for exactly 4 cycles, then returns to 0.
- Both valid from reset (req0=8'h11, req1=8'h22), held: grants alternate. Display shows 11, then 22, then 11, with a transfer every 5 cycles and each ready a 1-cycle pulse.
- req1 valid with 8'h55 during SHOW of req0: o_req1_ready stays 0 until SHOW ends, then is accepted in the first IDLE cycle. o_data stays 3A for the whole dwell.
- Assert i_freeze for 3 cycles in the middle of SHOW: o_busy lasts 4+3=7 cycles. No ready appears while frozen in IDLE.
- Assert i_reset asynchronously mid-SHOW: o_data=00, o_busy=0, readies=0 without waiting for a clock edge. A subsequent tie grants req0.
- No valids after a dwell ends: o_data holds the last value indefinitely and o_busy=0.
